ysyx_22051013_wb_arb: RTL and testbench
=======================================

YSYX_22051013_WB_ARB -- requirements
Module: ysyx_22051013_wb_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning register write-data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning entries buffering long-latency results.
REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning consecutive lost arbitrations before the FIFO is forced.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port wb_valid, input, 1, pipeline write-back request.
REQ-007 SHALL have ports wb_rd_addr (input, 5) and wb_rd_data (input, DATA_W), pipeline destination and data.
REQ-008 SHALL have port wb_ready, output, 1, pipeline request accepted this cycle.
REQ-009 SHALL have port md_valid, input, 1, mul/div result request.
REQ-010 SHALL have ports md_rd_addr (input, 5) and md_rd_data (input, DATA_W), mul/div destination and data.
REQ-011 SHALL have port md_ready, output, 1, FIFO not full.
REQ-012 SHALL have ports rs1_addr and rs2_addr, input, 5 each, decode-stage source registers.
REQ-013 SHALL have ports rs1_busy and rs2_busy, output, 1 each, source matches a pending FIFO entry.
REQ-014 SHALL have ports rf_we (output, 1), rf_waddr (output, 5) and rf_wdata (output, DATA_W), the registered regfile write port.

Function
REQ-015 SHALL push an md entry when md_valid & md_ready; md_ready = !full, with no bypass on pop in the same cycle.
REQ-016 SHALL treat an entry pushed in cycle N as eligible for grant from cycle N+1, with no empty-FIFO bypass.
REQ-017 SHALL select candidates each cycle from the pipeline (wb_valid) and the FIFO head (non-empty), at most one grant per cycle.
REQ-018 SHALL grant the pipeline by default; the FIFO head wins when wb_valid=0 or starv_cnt==STARVE_MAX.
REQ-019 SHALL drive wb_ready=1 except while a forced FIFO grant occurs (starv_cnt==STARVE_MAX & FIFO non-empty).
REQ-020 SHALL hold wb_rd_addr/wb_rd_data stable while the pipeline has wb_valid=1 & wb_ready=0; the pipeline owns this obligation and the block does not check it.
REQ-021 SHALL increment starv_cnt (3 bits, saturating at STARVE_MAX) when the FIFO is non-empty and the pipeline is granted.
REQ-022 SHALL clear starv_cnt on a FIFO grant or when the FIFO is empty.
REQ-023 SHALL register the granted request so rf_we/rf_waddr/rf_wdata are valid in cycle N+1 after a grant in cycle N (latency 1).
REQ-024 SHALL complete the handshake (pop or wb_ready) for a granted write to x0 while leaving rf_we=0.
REQ-025 SHALL drive rf_we=0, with rf_waddr/rf_wdata holding their last values, in cycles with no grant.
REQ-026 SHALL compute rsX_busy combinationally as 1 iff rsX_addr!=0 and it equals md_rd_addr of any valid FIFO entry.
REQ-027 SHALL keep rsX_busy high for an entry through its grant cycle and drop it the cycle after the pop.
REQ-028 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; full and empty SHALL derive from an occupancy count (0..FIFO_DEPTH).

Reset
REQ-029 SHALL, while rst=1, clear the FIFO (count 0, pointers 0), starv_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-030 SHALL drive md_ready=1 and wb_ready=1 during and after reset (empty FIFO, no forcing).
REQ-031 SHALL discard buffered results on a reset asserted mid-operation, with no rf write issued for them.

Structure
REQ-032 SHALL take DATA_W/REGADDR widths, STARVE_MAX and FIFO_DEPTH from the shared pip_cpu define file.
REQ-033 SHALL implement the FIFO with per-entry valid/address compare outputs as sub-module ysyx_22051013_wb_fifo; arbitration, starvation counter and output register SHALL live in the top module.

Verification
REQ-034 SHALL cover: wb_valid=1 only, addr 5, data 0x11 -> rf_we=1, waddr 5, wdata 0x11 next cycle; wb_ready=1.
REQ-035 SHALL cover: md push addr 7, data 0xAB, wb_valid=0 -> FIFO grant one cycle after push, rf write of 7/0xAB the cycle after that; rs1_addr=7 busy until pop.
REQ-036 SHALL cover: FIFO holding addr 9 with wb_valid=1 continuously -> four pipeline grants, then wb_ready=0 for one cycle, rf write of 9, starv_cnt=0.
REQ-037 SHALL cover: two md pushes with no pops -> md_ready=0; a third md_valid is held; after one pop, md_ready=1.
REQ-038 SHALL cover: wb write to x0 with data 0xFF -> wb_ready=1, rf_we stays 0; rs1_addr=0 never busy.
REQ-039 SHALL cover: rst asserted with 2 FIFO entries -> next cycle md_ready=1, rf_we=0, busy flags 0, no later write of the flushed entries.

Source files
------------

// File: rtl/ysyx_22051013_wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_wb_arb_pkg
// Shared widths and defaults for the write-back arbiter and its result FIFO.
// This is the common pip_cpu definition point: register address width,
// write-data width, FIFO depth and the starvation limit all come from here.
//
// Contents:
//   DATA_W_DEF      default register write-data width
//   REGADDR_W       register address width (32 architectural registers)
//   FIFO_DEPTH_DEF  default number of buffered mul/div results
//   STARVE_MAX_DEF  default number of lost arbitrations before forcing
//   STARV_W         width of the starvation counter
//   grant_e         which requester owns the register-file port this cycle
//   satInc          saturating increment used by the starvation counter
// ---------------------------------------------------------------------------
package ysyx_22051013_wb_arb_pkg;

    localparam int DATA_W_DEF     = 64;
    localparam int REGADDR_W      = 5;
    localparam int FIFO_DEPTH_DEF = 2;
    localparam int STARVE_MAX_DEF = 4;
    localparam int STARV_W        = 3;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WB   = 2'd1,
        GRANT_FIFO = 2'd2
    } grant_e;

    // Counts up by one but never past the given ceiling, so the counter
    // parks at the forcing threshold instead of wrapping back to zero.
    function automatic logic [STARV_W-1:0] satInc(
        input logic [STARV_W-1:0] value,
        input logic [STARV_W-1:0] ceiling
    );
        logic [STARV_W-1:0] result;
        if (value >= ceiling) begin
            result = ceiling;
        end else begin
            result = value + STARV_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/ysyx_22051013_wb_arb_fifo.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_wb_fifo
// Small result FIFO for long-latency (mul/div) write-backs. Each entry keeps
// a valid bit next to its destination register so the decode stage can ask
// "is this source still waiting for a buffered result?" against every entry
// in parallel.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   push_i             write an entry (ignored when full)
//   pushAddr_i/Data_i  destination register and data of the pushed entry
//   pop_i              retire the head entry (ignored when empty)
//   headAddr_o/Data_o  destination register and data of the head entry
//   empty_o, full_o    derived from the occupancy count
//   rs1Addr_i/rs2Addr_i decode-stage source registers to compare
//   rs1Match_o/rs2Match_o per-entry hit vectors (valid entry, same address)
// ---------------------------------------------------------------------------
module ysyx_22051013_wb_fifo
    import ysyx_22051013_wb_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [REGADDR_W-1:0] pushAddr_i,
    input  logic [DATA_W-1:0]    pushData_i,
    input  logic                 pop_i,
    output logic [REGADDR_W-1:0] headAddr_o,
    output logic [DATA_W-1:0]    headData_o,
    output logic                 empty_o,
    output logic                 full_o,
    input  logic [REGADDR_W-1:0] rs1Addr_i,
    input  logic [REGADDR_W-1:0] rs2Addr_i,
    output logic [DEPTH-1:0]     rs1Match_o,
    output logic [DEPTH-1:0]     rs2Match_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [REGADDR_W-1:0] addrMem_q [DEPTH];
    logic [DATA_W-1:0]    dataMem_q [DEPTH];
    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     valid_d;
    logic [PTR_W-1:0]     wrPtr_q;
    logic [PTR_W-1:0]     wrPtr_d;
    logic [PTR_W-1:0]     rdPtr_q;
    logic [PTR_W-1:0]     rdPtr_d;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic                 doPush;
    logic                 doPop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == FULL_CNT);
    assign doPush     = push_i & ~full_o;
    assign doPop      = pop_i & ~empty_o;
    assign headAddr_o = addrMem_q[rdPtr_q];
    assign headData_o = dataMem_q[rdPtr_q];

    // Pointer, valid-bit and occupancy bookkeeping. Pointers wrap at DEPTH
    // explicitly so non-power-of-two depths still work. Full/empty come
    // from the count, so equal pointers are never ambiguous. A push and a
    // pop in the same cycle never touch the same slot because a push needs
    // a free slot and a pop needs an occupied one.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        valid_d = valid_q;
        if (doPush) begin
            wrPtr_d          = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
            valid_d[wrPtr_q] = 1'b1;
        end
        if (doPop) begin
            rdPtr_d          = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
            valid_d[rdPtr_q] = 1'b0;
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register. Reset empties the FIFO outright, which is how
    // buffered results get discarded when the core is flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage. It needs no reset: nothing reads a slot as
    // meaningful unless its valid bit (or the count) says it is occupied.
    always_ff @(posedge clk) begin
        if (doPush) begin
            addrMem_q[wrPtr_q] <= pushAddr_i;
            dataMem_q[wrPtr_q] <= pushData_i;
        end
    end

    // Per-entry hazard compare. An entry stays valid through the cycle it
    // is popped, so a consumer sees it busy until the pop has taken effect.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rs1Match_o[i] = valid_q[i] && (addrMem_q[i] == rs1Addr_i);
            rs2Match_o[i] = valid_q[i] && (addrMem_q[i] == rs2Addr_i);
        end
    end

endmodule

// File: rtl/ysyx_22051013_wb_arb.sv
// ---------------------------------------------------------------------------
// ysyx_22051013_wb_arb
// Register-file write-back arbiter. The in-order pipeline and a buffered
// mul/div result FIFO share one register-file write port. The pipeline wins
// by default; the FIFO head wins when the pipeline is idle, or is forced in
// after STARVE_MAX consecutive lost arbitrations (stalling the pipeline for
// that one cycle). The winning write is registered onto the rf_* port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_valid/wb_rd_addr/wb_rd_data  pipeline write-back request
//   wb_ready                 pipeline request accepted this cycle
//   md_valid/md_rd_addr/md_rd_data  mul/div result request
//   md_ready                 FIFO has room
//   rs1_addr/rs2_addr        decode-stage source registers
//   rs1_busy/rs2_busy        source waits on a buffered mul/div result
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
// ---------------------------------------------------------------------------
module ysyx_22051013_wb_arb
    import ysyx_22051013_wb_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_valid,
    input  logic [REGADDR_W-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0]    wb_rd_data,
    output logic                 wb_ready,
    input  logic                 md_valid,
    input  logic [REGADDR_W-1:0] md_rd_addr,
    input  logic [DATA_W-1:0]    md_rd_data,
    output logic                 md_ready,
    input  logic [REGADDR_W-1:0] rs1_addr,
    input  logic [REGADDR_W-1:0] rs2_addr,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 rf_we,
    output logic [REGADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata
);

    localparam logic [STARV_W-1:0] STARVE_LIMIT = STARV_W'(STARVE_MAX);

    logic                 fifoPush;
    logic                 fifoPop;
    logic                 fifoEmpty;
    logic                 fifoFull;
    logic [REGADDR_W-1:0] headAddr;
    logic [DATA_W-1:0]    headData;
    logic [FIFO_DEPTH-1:0] rs1Match;
    logic [FIFO_DEPTH-1:0] rs2Match;
    logic                 starved;
    grant_e               grantSel;

    logic [STARV_W-1:0]   starvCnt_q;
    logic [STARV_W-1:0]   starvCnt_d;
    logic                 rfWe_q;
    logic                 rfWe_d;
    logic [REGADDR_W-1:0] rfWaddr_q;
    logic [REGADDR_W-1:0] rfWaddr_d;
    logic [DATA_W-1:0]    rfWdata_q;
    logic [DATA_W-1:0]    rfWdata_d;

    ysyx_22051013_wb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifoPush),
        .pushAddr_i (md_rd_addr),
        .pushData_i (md_rd_data),
        .pop_i      (fifoPop),
        .headAddr_o (headAddr),
        .headData_o (headData),
        .empty_o    (fifoEmpty),
        .full_o     (fifoFull),
        .rs1Addr_i  (rs1_addr),
        .rs2Addr_i  (rs2_addr),
        .rs1Match_o (rs1Match),
        .rs2Match_o (rs2Match)
    );

    // Handshakes. While reset is held nothing is pushed or granted and both
    // requesters are told they may proceed, so upstream logic coming out of
    // reset sees an open, empty arbiter. md_ready looks only at the current
    // occupancy: a pop this cycle does not free room for a same-cycle push.
    assign starved  = (starvCnt_q == STARVE_LIMIT);
    assign md_ready = rst | ~fifoFull;
    assign wb_ready = rst | ~(starved & ~fifoEmpty);
    assign fifoPush = ~rst & md_valid & ~fifoFull;
    assign fifoPop  = (grantSel == GRANT_FIFO);

    // x0 is hardwired zero, so a source naming it never waits on anything.
    assign rs1_busy = (rs1_addr != '0) && (|rs1Match);
    assign rs2_busy = (rs2_addr != '0) && (|rs2Match);

    assign rf_we    = rfWe_q;
    assign rf_waddr = rfWaddr_q;
    assign rf_wdata = rfWdata_q;

    // Arbitration. The FIFO only competes with entries already stored, so a
    // result pushed this cycle is first eligible next cycle. The FIFO head
    // takes the port when the pipeline is idle or when it has been starved
    // for STARVE_MAX grants in a row.
    always_comb begin
        grantSel = GRANT_NONE;
        if (!rst) begin
            if (!fifoEmpty && (!wb_valid || starved)) begin
                grantSel = GRANT_FIFO;
            end else if (wb_valid) begin
                grantSel = GRANT_WB;
            end
        end
    end

    // Starvation counter. It only tracks losses while something is actually
    // waiting in the FIFO; an empty FIFO or a FIFO grant starts it over.
    always_comb begin
        starvCnt_d = starvCnt_q;
        if (fifoEmpty || grantSel == GRANT_FIFO) begin
            starvCnt_d = '0;
        end else if (grantSel == GRANT_WB) begin
            starvCnt_d = satInc(starvCnt_q, STARVE_LIMIT);
        end
    end

    // Register-file write staging. A grant to x0 still completes its
    // handshake but produces no write; address and data only change when
    // a real write goes out, so they hold their last value otherwise.
    always_comb begin
        rfWe_d    = 1'b0;
        rfWaddr_d = rfWaddr_q;
        rfWdata_d = rfWdata_q;
        if (grantSel == GRANT_FIFO && headAddr != '0) begin
            rfWe_d    = 1'b1;
            rfWaddr_d = headAddr;
            rfWdata_d = headData;
        end else if (grantSel == GRANT_WB && wb_rd_addr != '0) begin
            rfWe_d    = 1'b1;
            rfWaddr_d = wb_rd_addr;
            rfWdata_d = wb_rd_data;
        end
    end

    // State registers for the starvation counter and the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            starvCnt_q <= '0;
            rfWe_q     <= 1'b0;
            rfWaddr_q  <= '0;
            rfWdata_q  <= '0;
        end else begin
            starvCnt_q <= starvCnt_d;
            rfWe_q     <= rfWe_d;
            rfWaddr_q  <= rfWaddr_d;
            rfWdata_q  <= rfWdata_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22051013_wb_arb.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22051013_wb_arb
// Self-checking bench for the write-back arbiter. A queue-based model tracks
// buffered results, the run of lost arbitrations and the expected register
// file write; scenario tasks drive the DUT and compare against it.
// ---------------------------------------------------------------------------
module tb_ysyx_22051013_wb_arb;

    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid;
    logic [4:0]        wb_rd_addr;
    logic [DATA_W-1:0] wb_rd_data;
    logic              wb_ready;
    logic              md_valid;
    logic [4:0]        md_rd_addr;
    logic [DATA_W-1:0] md_rd_data;
    logic              md_ready;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [4:0]        qAddr[$];
    logic [DATA_W-1:0] qData[$];
    int                starv;
    logic              expWbReady, expMdReady, expBusy1, expBusy2;
    logic              expRfWe;
    logic [4:0]        expRfWaddr;
    logic [DATA_W-1:0] expRfWdata;

    // Observed values (pre-edge combinational, post-edge registered)
    logic              obsWbReady, obsMdReady, obsBusy1, obsBusy2;
    logic              obsRfWe;
    logic [4:0]        obsRfWaddr;
    logic [DATA_W-1:0] obsRfWdata;

    ysyx_22051013_wb_arb #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_rd_addr (wb_rd_addr),
        .wb_rd_data (wb_rd_data),
        .wb_ready   (wb_ready),
        .md_valid   (md_valid),
        .md_rd_addr (md_rd_addr),
        .md_rd_data (md_rd_data),
        .md_ready   (md_ready),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    always #5 clk = ~clk;

    // One clock cycle: apply inputs, sample the combinational outputs before
    // the edge, advance the model across the edge, sample registered outputs.
    task automatic applyStimulus(input logic r, input logic wbV, input logic [4:0] wbA,
                                 input logic [DATA_W-1:0] wbD, input logic mdV,
                                 input logic [4:0] mdA, input logic [DATA_W-1:0] mdD,
                                 input logic [4:0] r1, input logic [4:0] r2);
        logic              nonEmpty;
        logic              fifoWins;
        logic [4:0]        a;
        logic [DATA_W-1:0] d;
        rst = r; wb_valid = wbV; wb_rd_addr = wbA; wb_rd_data = wbD;
        md_valid = mdV; md_rd_addr = mdA; md_rd_data = mdD;
        rs1_addr = r1; rs2_addr = r2;
        #1;
        obsWbReady = wb_ready; obsMdReady = md_ready;
        obsBusy1 = rs1_busy;   obsBusy2 = rs2_busy;
        nonEmpty = (qAddr.size() != 0);
        if (r) begin
            expWbReady = 1'b1;
            expMdReady = 1'b1;
        end else begin
            expMdReady = (qAddr.size() < FIFO_DEPTH);
            expWbReady = !(starv == STARVE_MAX && nonEmpty);
        end
        expBusy1 = 1'b0;
        expBusy2 = 1'b0;
        foreach (qAddr[i]) begin
            if (r1 != 0 && qAddr[i] == r1) expBusy1 = 1'b1;
            if (r2 != 0 && qAddr[i] == r2) expBusy2 = 1'b1;
        end
        @(posedge clk);
        if (r) begin
            qAddr.delete(); qData.delete();
            starv = 0; expRfWe = 1'b0; expRfWaddr = '0; expRfWdata = '0;
        end else begin
            fifoWins = nonEmpty && (!wbV || starv == STARVE_MAX);
            expRfWe = 1'b0;
            if (fifoWins) begin
                a = qAddr.pop_front();
                d = qData.pop_front();
                if (a != 0) begin expRfWe = 1'b1; expRfWaddr = a; expRfWdata = d; end
                starv = 0;
            end else if (wbV) begin
                if (wbA != 0) begin expRfWe = 1'b1; expRfWaddr = wbA; expRfWdata = wbD; end
                starv = nonEmpty ? ((starv + 1 > STARVE_MAX) ? STARVE_MAX : starv + 1) : 0;
            end else begin
                starv = 0;
            end
            if (mdV && expMdReady) begin
                qAddr.push_back(mdA);
                qData.push_back(mdD);
            end
        end
        #1;
        obsRfWe = rf_we; obsRfWaddr = rf_waddr; obsRfWdata = rf_wdata;
    endtask

    task automatic idleCycle(input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, r1, r2);
    endtask

    task automatic resetCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    endtask

    task automatic test_reset();
        resetCycle();
        checks++; if (obsMdReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_md_ready got %0b want 1", obsMdReady); end
        checks++; if (obsWbReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_wb_ready got %0b want 1", obsWbReady); end
        checks++; if (obsRfWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_we got %0b want 0", obsRfWe); end
        checks++; if (obsRfWaddr !== 5'd0) begin errors++; $display("[TB] FAIL reset_rf_waddr got %0d want 0", obsRfWaddr); end
        checks++; if (obsRfWdata !== 64'd0) begin errors++; $display("[TB] FAIL reset_rf_wdata got %0h want 0", obsRfWdata); end
        idleCycle(5'd3, 5'd4);
        checks++; if (obsBusy1 !== 1'b0 || obsBusy2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b%0b want 00", obsBusy1, obsBusy2); end
    endtask

    task automatic test_wb_only();
        resetCycle();
        applyStimulus(1'b0, 1'b1, 5'd5, 64'h11, 1'b0, 5'd0, '0, 5'd0, 5'd0);
        checks++; if (obsWbReady !== 1'b1) begin errors++; $display("[TB] FAIL wb_only_ready got %0b want 1", obsWbReady); end
        checks++; if (obsRfWe !== 1'b1 || obsRfWaddr !== 5'd5 || obsRfWdata !== 64'h11) begin errors++; $display("[TB] FAIL wb_only_write got we=%0b a=%0d d=%0h want we=1 a=5 d=11", obsRfWe, obsRfWaddr, obsRfWdata); end
        idleCycle(5'd0, 5'd0);
        checks++; if (obsRfWe !== 1'b0 || obsRfWaddr !== 5'd5 || obsRfWdata !== 64'h11) begin errors++; $display("[TB] FAIL wb_only_hold got we=%0b a=%0d d=%0h want we=0 a=5 d=11", obsRfWe, obsRfWaddr, obsRfWdata); end
    endtask

    task automatic test_md_single();
        resetCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd7, 64'hAB, 5'd7, 5'd0);
        checks++; if (obsMdReady !== 1'b1 || obsBusy1 !== 1'b0 || obsRfWe !== 1'b0) begin errors++; $display("[TB] FAIL md_push got rdy=%0b busy=%0b we=%0b want 1 0 0", obsMdReady, obsBusy1, obsRfWe); end
        idleCycle(5'd7, 5'd0);
        checks++; if (obsBusy1 !== 1'b1) begin errors++; $display("[TB] FAIL md_busy_grant got %0b want 1", obsBusy1); end
        checks++; if (obsRfWe !== 1'b1 || obsRfWaddr !== 5'd7 || obsRfWdata !== 64'hAB) begin errors++; $display("[TB] FAIL md_write got we=%0b a=%0d d=%0h want we=1 a=7 d=ab", obsRfWe, obsRfWaddr, obsRfWdata); end
        idleCycle(5'd7, 5'd0);
        checks++; if (obsBusy1 !== 1'b0 || obsRfWe !== 1'b0) begin errors++; $display("[TB] FAIL md_after_pop got busy=%0b we=%0b want 0 0", obsBusy1, obsRfWe); end
    endtask

    task automatic test_starvation();
        resetCycle();
        applyStimulus(1'b0, 1'b1, 5'd3, 64'h30, 1'b1, 5'd9, 64'h99, 5'd9, 5'd0);
        for (int k = 1; k <= STARVE_MAX; k++) begin
            applyStimulus(1'b0, 1'b1, 5'd3, 64'h30, 1'b0, 5'd0, '0, 5'd9, 5'd0);
            checks++; if (obsWbReady !== 1'b1 || obsRfWaddr !== 5'd3 || obsBusy1 !== 1'b1) begin errors++; $display("[TB] FAIL starve_wb_grant%0d got rdy=%0b a=%0d busy=%0b want 1 3 1", k, obsWbReady, obsRfWaddr, obsBusy1); end
        end
        applyStimulus(1'b0, 1'b1, 5'd3, 64'h30, 1'b0, 5'd0, '0, 5'd9, 5'd0);
        checks++; if (obsWbReady !== 1'b0) begin errors++; $display("[TB] FAIL starve_forced_ready got %0b want 0", obsWbReady); end
        checks++; if (obsRfWe !== 1'b1 || obsRfWaddr !== 5'd9 || obsRfWdata !== 64'h99) begin errors++; $display("[TB] FAIL starve_forced_write got we=%0b a=%0d d=%0h want we=1 a=9 d=99", obsRfWe, obsRfWaddr, obsRfWdata); end
        applyStimulus(1'b0, 1'b1, 5'd3, 64'h30, 1'b1, 5'd10, 64'hA0, 5'd9, 5'd0);
        checks++; if (obsWbReady !== 1'b1 || obsRfWaddr !== 5'd3 || obsBusy1 !== 1'b0) begin errors++; $display("[TB] FAIL starve_resume got rdy=%0b a=%0d busy=%0b want 1 3 0", obsWbReady, obsRfWaddr, obsBusy1); end
        for (int k = 1; k <= STARVE_MAX; k++) begin
            applyStimulus(1'b0, 1'b1, 5'd3, 64'h30, 1'b0, 5'd0, '0, 5'd10, 5'd0);
            checks++; if (obsWbReady !== 1'b1) begin errors++; $display("[TB] FAIL starve_restart%0d got %0b want 1", k, obsWbReady); end
        end
        applyStimulus(1'b0, 1'b1, 5'd3, 64'h30, 1'b0, 5'd0, '0, 5'd10, 5'd0);
        checks++; if (obsWbReady !== 1'b0 || obsRfWaddr !== 5'd10) begin errors++; $display("[TB] FAIL starve_second_force got rdy=%0b a=%0d want 0 10", obsWbReady, obsRfWaddr); end
    endtask

    task automatic test_fifo_full();
        resetCycle();
        applyStimulus(1'b0, 1'b1, 5'd1, 64'h1, 1'b1, 5'd10, 64'hA, 5'd0, 5'd0);
        applyStimulus(1'b0, 1'b1, 5'd1, 64'h1, 1'b1, 5'd11, 64'hB, 5'd0, 5'd0);
        applyStimulus(1'b0, 1'b1, 5'd1, 64'h1, 1'b1, 5'd12, 64'hC, 5'd10, 5'd11);
        checks++; if (obsMdReady !== 1'b0) begin errors++; $display("[TB] FAIL full_md_ready got %0b want 0", obsMdReady); end
        checks++; if (obsBusy1 !== 1'b1 || obsBusy2 !== 1'b1) begin errors++; $display("[TB] FAIL full_busy got %0b%0b want 11", obsBusy1, obsBusy2); end
        applyStimulus(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd12, 64'hC, 5'd12, 5'd0);
        checks++; if (obsMdReady !== 1'b0 || obsRfWaddr !== 5'd10) begin errors++; $display("[TB] FAIL full_pop_nobypass got rdy=%0b a=%0d want 0 10", obsMdReady, obsRfWaddr); end
        applyStimulus(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd12, 64'hC, 5'd12, 5'd0);
        checks++; if (obsMdReady !== 1'b1 || obsRfWaddr !== 5'd11 || obsBusy1 !== 1'b0) begin errors++; $display("[TB] FAIL full_reopen got rdy=%0b a=%0d busy=%0b want 1 11 0", obsMdReady, obsRfWaddr, obsBusy1); end
        idleCycle(5'd12, 5'd0);
        checks++; if (obsBusy1 !== 1'b1 || obsRfWaddr !== 5'd12 || obsRfWdata !== 64'hC) begin errors++; $display("[TB] FAIL full_third_write got busy=%0b a=%0d d=%0h want 1 12 c", obsBusy1, obsRfWaddr, obsRfWdata); end
    endtask

    task automatic test_x0();
        resetCycle();
        applyStimulus(1'b0, 1'b1, 5'd0, 64'hFF, 1'b1, 5'd0, 64'h55, 5'd0, 5'd0);
        checks++; if (obsWbReady !== 1'b1 || obsRfWe !== 1'b0) begin errors++; $display("[TB] FAIL x0_wb got rdy=%0b we=%0b want 1 0", obsWbReady, obsRfWe); end
        idleCycle(5'd0, 5'd0);
        checks++; if (obsBusy1 !== 1'b0 || obsRfWe !== 1'b0 || obsRfWaddr !== 5'd0) begin errors++; $display("[TB] FAIL x0_md got busy=%0b we=%0b a=%0d want 0 0 0", obsBusy1, obsRfWe, obsRfWaddr); end
        applyStimulus(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd4, 64'h44, 5'd0, 5'd0);
        idleCycle(5'd4, 5'd0);
        checks++; if (obsRfWe !== 1'b1 || obsRfWaddr !== 5'd4) begin errors++; $display("[TB] FAIL x0_popped got we=%0b a=%0d want 1 4", obsRfWe, obsRfWaddr); end
    endtask

    task automatic test_reset_flush();
        resetCycle();
        applyStimulus(1'b0, 1'b1, 5'd2, 64'h2, 1'b1, 5'd13, 64'hD, 5'd0, 5'd0);
        applyStimulus(1'b0, 1'b1, 5'd2, 64'h2, 1'b1, 5'd14, 64'hE, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd13, 5'd14);
        checks++; if (obsMdReady !== 1'b1 || obsWbReady !== 1'b1) begin errors++; $display("[TB] FAIL flush_during got md=%0b wb=%0b want 1 1", obsMdReady, obsWbReady); end
        checks++; if (obsRfWe !== 1'b0) begin errors++; $display("[TB] FAIL flush_rf_we got %0b want 0", obsRfWe); end
        idleCycle(5'd13, 5'd14);
        checks++; if (obsMdReady !== 1'b1 || obsBusy1 !== 1'b0 || obsBusy2 !== 1'b0) begin errors++; $display("[TB] FAIL flush_after got md=%0b busy=%0b%0b want 1 00", obsMdReady, obsBusy1, obsBusy2); end
        for (int k = 0; k < 3; k++) begin
            idleCycle(5'd13, 5'd14);
            checks++; if (obsRfWe !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_write%0d got %0b want 0", k, obsRfWe); end
        end
    endtask

    task automatic test_random();
        logic r, wbV, mdV;
        logic [4:0] wbA, mdA, r1, r2;
        logic [DATA_W-1:0] wbD, mdD;
        resetCycle();
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            wbV = ($urandom_range(0, 99) < 60);
            mdV = ($urandom_range(0, 99) < 50);
            wbA = 5'($urandom_range(0, 7));
            mdA = 5'($urandom_range(0, 7));
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            wbD = {$urandom, $urandom};
            mdD = {$urandom, $urandom};
            applyStimulus(r, wbV, wbA, wbD, mdV, mdA, mdD, r1, r2);
            checks++; if (obsWbReady !== expWbReady) begin errors++; $display("[TB] FAIL rnd%0d wb_ready got %0b want %0b", n, obsWbReady, expWbReady); end
            checks++; if (obsMdReady !== expMdReady) begin errors++; $display("[TB] FAIL rnd%0d md_ready got %0b want %0b", n, obsMdReady, expMdReady); end
            if (!r) begin
                checks++; if (obsBusy1 !== expBusy1 || obsBusy2 !== expBusy2) begin errors++; $display("[TB] FAIL rnd%0d busy got %0b%0b want %0b%0b", n, obsBusy1, obsBusy2, expBusy1, expBusy2); end
            end
            checks++; if (obsRfWe !== expRfWe) begin errors++; $display("[TB] FAIL rnd%0d rf_we got %0b want %0b", n, obsRfWe, expRfWe); end
            checks++; if (obsRfWaddr !== expRfWaddr || obsRfWdata !== expRfWdata) begin errors++; $display("[TB] FAIL rnd%0d rf_port got a=%0d d=%0h want a=%0d d=%0h", n, obsRfWaddr, obsRfWdata, expRfWaddr, expRfWdata); end
        end
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_rd_addr = '0; wb_rd_data = '0;
        md_valid = 1'b0; md_rd_addr = '0; md_rd_data = '0;
        rs1_addr = '0; rs2_addr = '0;
        starv = 0; expRfWe = 1'b0; expRfWaddr = '0; expRfWdata = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_wb_only();
        test_md_single();
        test_starvation();
        test_fifo_full();
        test_x0();
        test_reset_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
